// File: rtl/afc_pkg.sv
// Shared types and constants for the VCO automatic frequency calibration block.
package afc_pkg;

  localparam int CAP_CODE_W = 9;
  localparam logic [CAP_CODE_W-1:0] CAP_CODE_RST = 9'h100;
  // Bit index register width; must hold CAP_CODE_W-1.
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DECIDE  = 3'd3,
    ST_HOLD    = 3'd4
  } afc_state_e;

endpackage

// File: rtl/afc_freq_counter.sv
// Phase cycle counter (settle / measurement window / hold) plus a saturating
// counter of divided-VCO ticks seen while measurement is enabled.
module afc_freq_counter #(
  parameter int CYC_W = 9,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic [CYC_W-1:0] period,
  input  logic             tick_clear,
  input  logic             measure_en,
  input  logic             vco_tick,
  output logic             window_end,
  output logic [CNT_W-1:0] tick_count
);

  logic [CYC_W-1:0] cyc_cnt;

  // Last cycle of the current phase; the caller clears on it.
  assign window_end = (cyc_cnt == (period - 1'b1));

  // Phase cycle counter, restarted by the controller at every phase boundary.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_cnt <= '0;
    end else if (clear) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  // Tick counter: saturates at all-ones so a very fast VCO never wraps to a small count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_count <= '0;
    end else if (tick_clear) begin
      tick_count <= '0;
    end else if (measure_en && vco_tick && (tick_count != {CNT_W{1'b1}})) begin
      tick_count <= tick_count + 1'b1;
    end
  end

endmodule

// File: rtl/afc_sar_controller.sv
// Successive-approximation search of the VCO capacitor code. Each bit is
// trialled as 1, the VCO settles, ticks are counted over one window, and the
// bit is kept when the VCO runs faster than the target (larger code = slower).
// Request handshake: afc_start and load_manual are single-cycle requests with
// no backpressure; they are accepted only while the FSM is in IDLE (afc_busy
// low) and silently dropped otherwise. Start has priority over manual load.
module afc_sar_controller
  import afc_pkg::*;
#(
  parameter int SETTLE_LEN = 64,
  parameter int WINDOW_LEN = 256,
  parameter int HOLD_LEN   = 8,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  afc_start,
  input  logic                  afc_mode_cfg,
  input  logic [CNT_W-1:0]      target_count,
  input  logic                  vco_tick,
  input  logic                  load_manual,
  input  logic [CAP_CODE_W-1:0] manual_code,
  output logic [CAP_CODE_W-1:0] cap_code,
  output logic                  afc_busy,
  output logic                  afc_mode,
  output logic                  afc_done,
  output afc_state_e            dbg_state
);

  localparam int MAX_SW  = (SETTLE_LEN > WINDOW_LEN) ? SETTLE_LEN : WINDOW_LEN;
  localparam int PER_MAX = (MAX_SW > HOLD_LEN) ? MAX_SW : HOLD_LEN;
  localparam int CYC_W   = $clog2(PER_MAX + 1);

  afc_state_e            state, state_next;
  logic [CNT_W-1:0]      target_q;
  logic [IDX_W-1:0]      idx;
  logic [CAP_CODE_W-1:0] cap_code_q;
  logic                  busy_q, done_q, mode_q;

  logic [CYC_W-1:0]      period;
  logic                  window_end;
  logic [CNT_W-1:0]      tick_count;
  logic                  cyc_clear, tick_clear, measure_en;
  logic [CAP_CODE_W-1:0] bit_mask, next_mask, decided_code;
  logic                  vco_fast;

  assign cap_code  = cap_code_q;
  assign afc_busy  = busy_q;
  assign afc_done  = done_q;
  assign afc_mode  = mode_q;
  assign dbg_state = state;

  // Phase length for the cycle counter, selected by the current state.
  always_comb begin
    period = CYC_W'(SETTLE_LEN);
    case (state)
      ST_MEASURE: period = CYC_W'(WINDOW_LEN);
      ST_HOLD:    period = CYC_W'(HOLD_LEN);
      default:    ;
    endcase
  end

  assign cyc_clear  = (state == ST_IDLE) || (state == ST_DECIDE) || window_end;
  assign tick_clear = (state == ST_IDLE) || (state == ST_DECIDE);
  assign measure_en = (state == ST_MEASURE);

  afc_freq_counter #(
    .CYC_W (CYC_W),
    .CNT_W (CNT_W)
  ) u_freq_counter (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (cyc_clear),
    .period     (period),
    .tick_clear (tick_clear),
    .measure_en (measure_en),
    .vco_tick   (vco_tick),
    .window_end (window_end),
    .tick_count (tick_count)
  );

  // SAR step: resolve the trial bit and arm the next lower one (none after bit 0).
  always_comb begin
    bit_mask     = {{(CAP_CODE_W-1){1'b0}}, 1'b1} << idx;
    next_mask    = bit_mask >> 1;
    vco_fast     = (tick_count > target_q);
    decided_code = (cap_code_q & ~bit_mask) | (vco_fast ? bit_mask : '0) | next_mask;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (afc_start) state_next = ST_SETTLE;
      ST_SETTLE:  if (window_end) state_next = ST_MEASURE;
      ST_MEASURE: if (window_end) state_next = ST_DECIDE;
      ST_DECIDE:  state_next = (idx == '0) ? ST_HOLD : ST_SETTLE;
      ST_HOLD:    if (window_end) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Code register, bit index, target latch and registered busy/done flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_code_q <= CAP_CODE_RST;
      idx        <= '0;
      target_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (afc_start) begin
            target_q   <= target_count;
            idx        <= IDX_W'(CAP_CODE_W - 1);
            cap_code_q <= CAP_CODE_RST;
            busy_q     <= 1'b1;
          end else if (load_manual) begin
            cap_code_q <= manual_code;
          end
        end
        ST_DECIDE: begin
          cap_code_q <= decided_code;
          if (idx != '0) idx <= idx - 1'b1;
        end
        ST_HOLD: begin
          if (window_end) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Mode bit is a plain one-cycle delay, independent of the FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= afc_mode_cfg;
    end
  end

endmodule

// File: tb/tb_afc_sar_controller.sv
// Bench for afc_sar_controller: an IDLE-mode vector table plus full calibration
// runs checked cycle by cycle against a reference SAR model.
module tb_afc_sar_controller;
  import afc_pkg::*;

  localparam int S   = 4;
  localparam int W_A = 16;
  localparam int W_B = 32;
  localparam int H   = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        load_a = 1'b0, load_b = 1'b0;
  logic        mode_cfg = 1'b0;
  logic        vco_tick = 1'b0;
  logic [11:0] tgt_a = '0;
  logic [3:0]  tgt_b = '0;
  logic [8:0]  manual = '0;
  logic [8:0]  code_a, code_b;
  logic        busy_a, busy_b, mode_a, mode_b, done_a, done_b;
  afc_state_e  st_a, st_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       load;
    logic [8:0] manual;
    logic       cfg;
    logic [8:0] exp_code;
    logic       exp_mode;
  } vec_t;
  vec_t vecs[6];

  // clock
  always #5 clk = ~clk;

  afc_sar_controller #(.SETTLE_LEN(S), .WINDOW_LEN(W_A), .HOLD_LEN(H), .CNT_W(12)) dut_a (
    .clk(clk), .rstn(rstn), .afc_start(start_a), .afc_mode_cfg(mode_cfg),
    .target_count(tgt_a), .vco_tick(vco_tick), .load_manual(load_a),
    .manual_code(manual), .cap_code(code_a), .afc_busy(busy_a),
    .afc_mode(mode_a), .afc_done(done_a), .dbg_state(st_a)
  );

  afc_sar_controller #(.SETTLE_LEN(S), .WINDOW_LEN(W_B), .HOLD_LEN(H), .CNT_W(4)) dut_b (
    .clk(clk), .rstn(rstn), .afc_start(start_b), .afc_mode_cfg(mode_cfg),
    .target_count(tgt_b), .vco_tick(vco_tick), .load_manual(load_b),
    .manual_code(manual), .cap_code(code_b), .afc_busy(busy_b),
    .afc_mode(mode_b), .afc_done(done_b), .dbg_state(st_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One calibration on instance sel (0: window 16 / 12-bit, 1: window 32 / 4-bit).
  // kind: 0 no ticks, 1 ticks always, 2 rate from model code, 3 random.
  // opt: 0 plain, 1 requests mid-MEASURE, 2 start+load together,
  //      3 reset during third MEASURE, 4 start held high throughout.
  task automatic run_cal(input int sel, input int tgt, input int kind, input int opt,
                         input int exp_final, input string tag);
    int w, p, cmax, total, mcnt, mcode, errs, step, off, b;
    logic in_meas, tk;
    logic [8:0] act_code, exp_code;
    logic act_busy, act_done, exp_busy, exp_done;
    w = sel ? W_B : W_A;
    p = S + w + 1;
    cmax = sel ? 15 : 4095;
    total = 9 * p + H;
    mcode = 256;
    mcnt = 0;
    errs = 0;
    @(negedge clk);
    if (sel != 0) begin start_b = 1'b1; tgt_b = 4'(tgt); end
    else begin start_a = 1'b1; tgt_a = 12'(tgt); end
    if (opt == 2) begin load_a = 1'b1; manual = 9'h0AA; end
    for (int c = 0; c <= total + 1; c++) begin
      @(negedge clk);
      if (opt != 4) begin start_a = 1'b0; start_b = 1'b0; end
      load_a = 1'b0;
      act_code = (sel != 0) ? code_b : code_a;
      act_busy = (sel != 0) ? busy_b : busy_a;
      act_done = (sel != 0) ? done_b : done_a;
      exp_code = 9'(mcode);
      exp_busy = (c < total);
      exp_done = (c == total);
      if (opt == 4 && c == total + 1) begin exp_code = 9'h100; exp_busy = 1'b1; end
      if (act_code !== exp_code || act_busy !== exp_busy || act_done !== exp_done) begin
        if (errs == 0)
          $display("  %s cycle %0d: code=%h/%h busy=%b/%b done=%b/%b", tag, c,
                   act_code, exp_code, act_busy, exp_busy, act_done, exp_done);
        errs++;
      end
      if (c == total) begin
        check({tag, "_done"}, 32'(act_done), 32'd1);
        check({tag, "_final"}, 32'(act_code), 32'(mcode));
        if (exp_final >= 0) check({tag, "_const"}, 32'(act_code), 32'(exp_final));
      end
      if (opt == 3 && c == 2 * p + S + 3) begin
        rstn = 1'b0;
        #1;
        check({tag, "_rst_busy"}, 32'((sel != 0) ? busy_b : busy_a), 32'd0);
        check({tag, "_rst_code"}, 32'((sel != 0) ? code_b : code_a), 32'h100);
        repeat (3) @(negedge clk);
        check({tag, "_rst_nodone"}, 32'((sel != 0) ? done_b : done_a), 32'd0);
        rstn = 1'b1;
        vco_tick = 1'b0;
        check({tag, "_trace"}, 32'(errs), 32'd0);
        return;
      end
      if (opt == 1 && c == p + S + 5) begin
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        load_a = 1'b1;
        manual = 9'h055;
      end
      // stimulus for this cycle and the model's view of it
      step = c / p;
      off = c % p;
      in_meas = (step < 9) && (off >= S) && (off < S + w);
      case (kind)
        0: tk = 1'b0;
        1: tk = 1'b1;
        2: tk = in_meas && ((off - S) < (511 - mcode) / 32);
        default: tk = 1'($urandom_range(0, 1));
      endcase
      vco_tick = tk;
      if (in_meas && tk && mcnt < cmax) mcnt++;
      if (step < 9 && off == S + w) begin
        b = 8 - step;
        if (mcnt <= tgt) mcode = mcode - (1 << b);
        if (b > 0) mcode = mcode + (1 << (b - 1));
        mcnt = 0;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    vco_tick = 1'b0;
    check({tag, "_trace"}, 32'(errs), 32'd0);
    if (opt == 4) begin
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
    end
  endtask

  // watchdog
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecs[0] = '{1'b1, 9'h055, 1'b1, 9'h055, 1'b1};
    vecs[1] = '{1'b0, 9'h1FF, 1'b0, 9'h055, 1'b0};
    vecs[2] = '{1'b1, 9'h1AA, 1'b1, 9'h1AA, 1'b1};
    vecs[3] = '{1'b1, 9'h000, 1'b1, 9'h000, 1'b1};
    vecs[4] = '{1'b0, 9'h123, 1'b0, 9'h000, 1'b0};
    vecs[5] = '{1'b1, 9'h100, 1'b0, 9'h100, 1'b0};

    // reset
    mode_cfg = 1'b1;
    #12;
    check("rst_code_a", 32'(code_a), 32'h100);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_mode_a", 32'(mode_a), 32'd0);
    check("rst_code_b", 32'(code_b), 32'h100);
    @(negedge clk);
    mode_cfg = 1'b0;
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_code", 32'(code_a), 32'h100);
    check("idle_busy", 32'(busy_a), 32'd0);
    check("idle_done", 32'(done_a), 32'd0);

    // IDLE vector table: manual loads and mode delay
    for (int i = 0; i < 6; i++) begin
      load_a = vecs[i].load;
      manual = vecs[i].manual;
      mode_cfg = vecs[i].cfg;
      @(negedge clk);
      load_a = 1'b0;
      check($sformatf("vec%0d_code", i), 32'(code_a), 32'(vecs[i].exp_code));
      check($sformatf("vec%0d_mode", i), 32'(mode_a), 32'(vecs[i].exp_mode));
      check($sformatf("vec%0d_busy", i), 32'(busy_a), 32'd0);
    end
    mode_cfg = 1'b0;

    // directed calibrations
    run_cal(0, 8, 2, 0, -1, "converge");
    run_cal(0, 15, 1, 0, 9'h1FF, "all_fast");
    run_cal(0, 5, 0, 0, 9'h000, "no_ticks");
    run_cal(0, 16, 1, 0, 9'h000, "equal");
    run_cal(1, 14, 1, 0, 9'h1FF, "saturate");
    run_cal(0, 8, 3, 1, -1, "ignore_req");

    // manual load accepted again once idle
    @(negedge clk);
    load_a = 1'b1;
    manual = 9'h055;
    @(negedge clk);
    load_a = 1'b0;
    check("idle_load", 32'(code_a), 32'h055);

    run_cal(0, 8, 3, 2, -1, "start_load");
    run_cal(0, 8, 3, 3, -1, "abort");
    run_cal(0, 8, 3, 0, -1, "after_abort");
    run_cal(0, 8, 3, 4, -1, "held_start");

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      if (sel != 0) run_cal(1, int'($urandom_range(0, 15)), 3, 0, -1, $sformatf("rand%0d", r));
      else run_cal(0, int'($urandom_range(4, 12)), 3, 0, -1, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
